rtype_program_loader: RTL and testbench
=======================================

// Module: rtype_program_loader
// PURPOSE
//  Encoder/writer side of the R-type datapath: accepts R-type instruction fields over a valid/ready
//  stream, packs each into a 32-bit RV32I R-type word, buffers the words, and writes them to
//  consecutive instruction-memory words. While loading, it holds the processor core in reset via
//  cpu_rst and releases the core once the last instruction has been committed to memory.
// PARAMETERS
//  BASE_ADDR   32'h0  byte address of the first instruction written
//  MEM_WORDS   64     instruction-memory capacity in 32-bit words (>=1)
//  FIFO_DEPTH  4      encoded-word buffer depth (power of 2, >=2)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   begin a load session (pulse)
//  in_valid    in   1   instruction fields valid
//  in_ready    out  1   loader can accept fields this cycle
//  in_funct7   in   7   funct7 field
//  in_rs2      in   5   rs2 index
//  in_rs1      in   5   rs1 index
//  in_funct3   in   3   funct3 field
//  in_rd       in   5   rd index
//  in_last     in   1   marks the final instruction of the program
//  imem_we     out  1   instruction-memory write request
//  imem_addr   out  32  byte address of the write (word aligned)
//  imem_wdata  out  32  encoded instruction
//  imem_ready  in   1   memory accepts the write this cycle
//  cpu_rst     out  1   reset to processor core; high unless state==DONE
//  done        out  1   load completed successfully
//  err         out  1   sticky overflow error for the current session
//  count       out  7   instructions written this session ($clog2(MEM_WORDS)+1 bits)
// BEHAVIOUR
//  - Reset (async): state=IDLE, FIFO flushed, imem_addr=BASE_ADDR, count=0, imem_we=0,
//    imem_wdata=0, in_ready=0, done=0, err=0, cpu_rst=1.
//  - States: IDLE -start-> LOAD; LOAD -last word written-> DONE; LOAD -overflow-> ERR;
//    DONE/ERR -start-> LOAD. start is ignored in LOAD. On entry to LOAD: FIFO flushed,
//    imem_addr=BASE_ADDR, count=0, done=0, err=0, last_seen=0.
//  - Encoding: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}; no field checking.
//  - in_ready = (state==LOAD) && !fifo_full && !last_seen. A transfer occurs when in_valid&&in_ready;
//    the word is pushed and enters the FIFO the next cycle. Transfer with in_last sets last_seen.
//    Push is refused while full even if a pop happens in the same cycle.
//  - Write side: imem_we = (state==LOAD) && !fifo_empty; imem_wdata = FIFO head; imem_addr is a
//    register. A write completes on a cycle with imem_we && imem_ready: FIFO pops, imem_addr += 4,
//    count += 1. While imem_ready=0, we/addr/wdata hold stable. Minimum latency from accept to
//    imem_we is 1 cycle; sustained rate is 1 word/cycle when imem_ready=1.
//  - Completion: the write that empties the FIFO with last_seen=1 moves to DONE in the next cycle;
//    done=1 and cpu_rst=0 from that cycle on.
//  - Overflow: if a write is pending with count==MEM_WORDS, imem_we is suppressed, err=1, state->ERR;
//    cpu_rst stays 1, in_ready=0, remaining FIFO contents are discarded.
//  - Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.
//  - Reset asserted mid-session: everything returns to reset values immediately; no partial write
//    is retried.
// STRUCTURE
//  - Shared header rv_defs.vh: OPCODE_RTYPE (7'b0110011), FUNCT3_*/FUNCT7_* constants,
//    loader state encodings (IDLE/LOAD/DONE/ERR).
//  - One sub-module: instr_fifo (synchronous FIFO, width 32, depth FIFO_DEPTH, push/pop/full/empty,
//    flush input, async active-high reset). Encoder and FSM live in this module.
// TESTING
//  1. start; feed ADD x3,x1,x2 (f7=0,rs2=2,rs1=1,f3=0,rd=3,last=1), imem_ready=1 -> one write
//     addr=0x0 data=0x002081B3; done=1, cpu_rst=0, count=1.
//  2. Feed ADD then SUB x5,x3,x4 (f7=0x20), last on SUB -> writes 0x002081B3@0x0,
//     0x404182B3@0x4 in order; done only after second write.
//  3. imem_ready=0 for 10 cycles while feeding 6 words -> in_ready drops after FIFO_DEPTH
//     accepts; we/addr/wdata stable; after release all 6 written to 0x0..0x14 in order, no loss.
//  4. MEM_WORDS=4, feed 5 words -> 4 writes, 5th suppressed, err=1, cpu_rst=1, done=0.
//  5. Assert rst after 2 of 4 writes -> same-cycle cpu_rst=1, imem_we=0, count=0; new start
//     reloads from BASE_ADDR.
//  6. start in LOAD ignored; start in DONE -> cpu_rst=1, done=0, count=0, addr=BASE_ADDR.

Source files
------------

// File: rtl/rtype_program_loader_pkg.sv
// Shared definitions for the R-type program loader: opcode and funct
// constants, loader FSM state encoding, and the R-type word packer.
package rtype_program_loader_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;  // SUB / SRA

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } loader_state_t;

  // Packs fields into an RV32I R-type word; fields are not range checked.
  function automatic logic [31:0] encode_rtype(
    input logic [6:0] funct7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] funct3,
    input logic [4:0] rd
  );
    return {funct7, rs2, rs1, funct3, rd, OPCODE_RTYPE};
  endfunction

endpackage

// File: rtl/rtype_program_loader_instr_fifo.sv
// Synchronous FIFO holding encoded instruction words.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   flush         empties the FIFO (pointers cleared), overrides push/pop
//   push, din     write request and data; ignored when full
//   pop           read request; ignored when empty
//   dout          current head word (combinational from storage)
//   full, empty   occupancy flags
//   level         number of stored words
module rtype_program_loader_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == DEPTH_C);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rtype_program_loader.sv
// R-type program loader: accepts instruction fields over a valid/ready
// stream, packs them into RV32I R-type words, buffers them and writes them
// to consecutive instruction-memory words starting at BASE_ADDR. The core
// is held in reset (cpu_rst=1) until the whole program has been written.
// Ports:
//   clk, rst                     clock / asynchronous active-high reset
//   start                        begin a load session (ignored while loading)
//   in_valid, in_ready           field stream handshake
//   in_funct7..in_rd, in_last    instruction fields, end-of-program marker
//   imem_we, imem_addr,
//   imem_wdata, imem_ready       instruction-memory write port
//   cpu_rst                      core reset, low only after a successful load
//   done, err                    session completed / overflowed
//   count                        words written this session
module rtype_program_loader
  import rtype_program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_funct7,
  input  logic [4:0]                  in_rs2,
  input  logic [4:0]                  in_rs1,
  input  logic [2:0]                  in_funct3,
  input  logic [4:0]                  in_rd,
  input  logic                        in_last,
  output logic                        imem_we,
  output logic [31:0]                 imem_addr,
  output logic [31:0]                 imem_wdata,
  input  logic                        imem_ready,
  output logic                        cpu_rst,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(MEM_WORDS):0]  count
);
  localparam int CW = $clog2(MEM_WORDS) + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] MEM_WORDS_C = MEM_WORDS[CW-1:0];
  localparam logic [LW-1:0] ONE_ENTRY   = LW'(1);

  loader_state_t  state_reg;
  loader_state_t  state_next;
  logic           last_seen_reg;
  logic [31:0]    addr_reg;
  logic [CW-1:0]  count_reg;

  logic           loading;
  logic           pending;
  logic           overflow;
  logic           write_done;
  logic           push;
  logic           start_session;
  logic           fifo_flush;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LW-1:0]  fifo_level;
  logic [31:0]    fifo_dout;
  logic [31:0]    enc_word;

  assign enc_word = encode_rtype(in_funct7, in_rs2, in_rs1, in_funct3, in_rd);

  assign loading       = (state_reg == ST_LOAD);
  assign pending       = loading && !fifo_empty;
  // A word waiting with memory already full cannot be placed anywhere.
  assign overflow      = pending && (count_reg == MEM_WORDS_C);
  assign write_done    = imem_we && imem_ready;
  assign push          = in_valid && in_ready;
  assign start_session = start && !loading;
  // Overflow discards whatever is still buffered.
  assign fifo_flush    = start_session || overflow;

  rtype_program_loader_instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push),
    .din   (enc_word),
    .pop   (write_done),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst    = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = !fifo_full && !last_seen_reg;
        imem_we  = pending && !overflow;
        if (overflow) begin
          state_next = ST_ERR;
        end else if (write_done && last_seen_reg && fifo_level == ONE_ENTRY) begin
          // No push can coincide here: in_ready is low once last_seen is set.
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_next = ST_LOAD;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= BASE_ADDR;
      count_reg     <= '0;
      last_seen_reg <= 1'b0;
    end else if (start_session) begin
      addr_reg      <= BASE_ADDR;
      count_reg     <= '0;
      last_seen_reg <= 1'b0;
    end else begin
      if (write_done) begin
        addr_reg  <= addr_reg + 32'd4;
        count_reg <= count_reg + 1'b1;
      end
      if (push && in_last) begin
        last_seen_reg <= 1'b1;
      end
    end
  end

  assign imem_addr  = addr_reg;
  // Head storage is undefined when empty; show zero whenever no write is requested.
  assign imem_wdata = imem_we ? fifo_dout : 32'h0;
  assign count      = count_reg;

endmodule

// File: tb/tb_rtype_program_loader.sv
module tb_rtype_program_loader;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_last = 1'b0;
  logic        fixed_rdy = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        rnd_bit = 1'b0;
  logic        imem_ready;
  assign imem_ready = rand_rdy ? rnd_bit : fixed_rdy;

  logic        in_ready, imem_we, cpu_rst, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [6:0]  count;

  logic        in_ready_s, imem_we_s, cpu_rst_s, done_s, err_s;
  logic [31:0] imem_addr_s, imem_wdata_s;
  logic [2:0]  count_s;

  rtype_program_loader #(.BASE_ADDR(BASE), .MEM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct7(in_funct7), .in_rs2(in_rs2), .in_rs1(in_rs1), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .cpu_rst(cpu_rst), .done(done),
    .err(err), .count(count)
  );

  rtype_program_loader #(.BASE_ADDR(BASE), .MEM_WORDS(4), .FIFO_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_funct7(in_funct7), .in_rs2(in_rs2), .in_rs1(in_rs1), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_last(in_last), .imem_we(imem_we_s), .imem_addr(imem_addr_s),
    .imem_wdata(imem_wdata_s), .imem_ready(imem_ready), .cpu_rst(cpu_rst_s), .done(done_s),
    .err(err_s), .count(count_s)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: an RV32I R-type word as a weighted sum of its fields.
  function automatic logic [31:0] model_word(input int unsigned f7, input int unsigned rs2,
                                             input int unsigned rs1, input int unsigned f3,
                                             input int unsigned rd);
    return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [6:0]  f7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[5];

  int  n_writes = 0;
  int  n_writes_s = 0;
  bit  mon_en = 1'b1;
  bit  sel_small = 1'b0;
  int  sess_idx = 0;
  bit  hold = 1'b0;
  logic [31:0] h_addr, h_data;

  // Random memory back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // Write monitor: checks each completed write against the expected queue
  // and that a stalled request does not change.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we_s && imem_ready && !rst) n_writes_s++;
      if (rst || !mon_en) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_we", 32'(imem_we), 32'd1);
          chk("hold_addr", imem_addr, h_addr);
          chk("hold_data", imem_wdata, h_data);
        end
        if (imem_we && imem_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write actual=%h@%h expected=none", imem_wdata, imem_addr);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e.addr);
            chk("wr_data", imem_wdata, e.data);
          end
          n_writes++;
        end
        hold = imem_we && !imem_ready;
        h_addr = imem_addr;
        h_data = imem_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    sess_idx = 0;
  endtask

  task automatic send(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                      input logic [2:0] f3, input logic [4:0] rd, input logic last,
                      input logic [31:0] exp_data);
    bit ok;
    logic rdy;
    ok = 1'b0;
    in_funct7 = f7; in_rs2 = rs2; in_rs1 = rs1; in_funct3 = f3; in_rd = rd;
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      rdy = sel_small ? in_ready_s : in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout actual=no_accept expected=accept");
    end else if (!sel_small) begin
      exp_q.push_back('{addr: BASE + 32'(4 * sess_idx), data: exp_data});
      sess_idx++;
    end
  endtask

  task automatic send_rand(input logic last);
    logic [6:0] f7;
    logic [4:0] a, b, d;
    logic [2:0] f3;
    f7 = 7'($urandom); a = 5'($urandom); b = 5'($urandom); f3 = 3'($urandom); d = 5'($urandom);
    send(f7, a, b, f3, d, last, model_word(f7, a, b, f3, d));
  endtask

  task automatic wait_done(input string name, input int lim);
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  int base;
  int nw;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{f7: 7'h00, rs2: 5'd2, rs1: 5'd1, f3: 3'd0, rd: 5'd3, word: 32'h002081B3};
    tbl[1] = '{f7: 7'h20, rs2: 5'd4, rs1: 5'd3, f3: 3'd0, rd: 5'd5, word: 32'h404182B3};
    tbl[2] = '{f7: 7'h00, rs2: 5'd9, rs1: 5'd8, f3: 3'd7, rd: 5'd7, word: 32'h009473B3};
    tbl[3] = '{f7: 7'h7F, rs2: 5'd31, rs1: 5'd31, f3: 3'd7, rd: 5'd31, word: 32'hFFFFFFB3};
    tbl[4] = '{f7: 7'h00, rs2: 5'd0, rs1: 5'd0, f3: 3'd0, rd: 5'd0, word: 32'h00000033};

    // Reset state
    repeat (2) tick();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Single ADD
    start_session();
    base = n_writes;
    send(tbl[0].f7, tbl[0].rs2, tbl[0].rs1, tbl[0].f3, tbl[0].rd, 1'b1, tbl[0].word);
    wait_done("t1_done", 50);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_writes", 32'(n_writes - base), 32'd1);

    // Table program, last on the final entry
    start_session();
    chk("t2_cpu_rst_reload", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t2_done_early", 32'(done), 32'd0);
      send(tbl[i].f7, tbl[i].rs2, tbl[i].rs1, tbl[i].f3, tbl[i].rd, 1'(i == 4), tbl[i].word);
    end
    wait_done("t2_done", 50);
    chk("t2_count", 32'(count), 32'd5);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: FIFO fills, request holds, nothing lost
    start_session();
    fixed_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    @(negedge clk);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_we_stalled", 32'(imem_we), 32'd1);
    chk("t3_addr_stalled", imem_addr, BASE);
    repeat (6) tick();
    fixed_rdy = 1'b1;
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done("t3_done", 50);
    chk("t3_count", 32'(count), 32'd6);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overflow on the 4-word instance
    mon_en = 1'b0;
    sel_small = 1'b1;
    start_session();
    base = n_writes_s;
    for (int i = 0; i < 5; i++) send_rand(1'(i == 4));
    repeat (5) tick();
    chk("t4_err", 32'(err_s), 32'd1);
    chk("t4_cpu_rst", 32'(cpu_rst_s), 32'd1);
    chk("t4_done", 32'(done_s), 32'd0);
    chk("t4_writes", 32'(n_writes_s - base), 32'd4);
    chk("t4_count", 32'(count_s), 32'd4);
    chk("t4_we", 32'(imem_we_s), 32'd0);
    chk("t4_in_ready", 32'(in_ready_s), 32'd0);
    sel_small = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Reset mid-session after two writes
    start_session();
    base = n_writes;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    chk("t5_writes_before", 32'(n_writes - base), 32'd2);
    chk("t5_we_pending", 32'(imem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t5_we", 32'(imem_we), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_addr", imem_addr, BASE);
    exp_q.delete();
    tick();
    rst = 1'b0;
    start_session();
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done("t5_reload_done", 50);
    chk("t5_reload_count", 32'(count), 32'd2);

    // start ignored in LOAD; start in DONE restarts
    start_session();
    send_rand(1'b0);
    tick();
    chk("t6_count_before", 32'(count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_ignored_count", 32'(count), 32'd1);
    chk("t6_ignored_addr", imem_addr, BASE + 32'd4);
    chk("t6_ignored_in_ready", 32'(in_ready), 32'd1);
    send_rand(1'b1);
    wait_done("t6_done", 50);
    chk("t6_count", 32'(count), 32'd2);
    start_session();
    chk("t6_restart_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_restart_done", 32'(done), 32'd0);
    chk("t6_restart_count", 32'(count), 32'd0);
    chk("t6_restart_addr", imem_addr, BASE);
    send_rand(1'b1);
    wait_done("t6_restart_finish", 50);

    // Randomized sessions with random back-pressure
    rand_rdy = 1'b1;
    for (int s = 0; s < 6; s++) begin
      start_session();
      nw = int'($urandom_range(1, 12));
      for (int i = 0; i < nw; i++) send_rand(1'(i == nw - 1));
      wait_done("rnd_done", 400);
      chk("rnd_count", 32'(count), 32'(nw));
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    end
    rand_rdy = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
